// File: rtl/md_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// operation codes, FSM states and a sign-correction helper.
package md_defs;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_NOP7  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } md_state_e;

   localparam int NEG_MAXW = 128;

   // Low bits of a two's-complement negation do not depend on the
   // upper bits, so callers zero-extend, negate, then truncate.
   function automatic logic [NEG_MAXW-1:0] neg_if(
      input logic [NEG_MAXW-1:0] v,
      input logic                en
   );
      return en ? ((~v) + NEG_MAXW'(1)) : v;
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/result bus between the pipeline and the md unit.
interface md_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       MDOp;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output start, MDOp, A, B,
      input  busy, HI, LO
   );

   modport slave (
      input  start, MDOp, A, B,
      output busy, HI, LO
   );
endinterface

// File: rtl/md_unit_divstep.sv
// One restoring division step: shift in the next dividend bit,
// subtract the divisor when it fits, record the quotient bit.
module md_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   logic [WIDTH:0] shifted;
   logic           fits;

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      fits    = shifted >= {1'b0, divisor};
      rem_nxt = fits ? WIDTH'(shifted - {1'b0, divisor})
                     : shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Works on magnitudes; signs are restored in a final FIX cycle.
module md_unit
   import md_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   md_unit_if.slave   bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e        state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opd;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic             neg_q;
   logic             neg_r;
   logic             is_div;
   logic             dz;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   md_op_e           op;
   logic             sgn_op;
   logic             sa;
   logic             sb;
   logic [WIDTH-1:0] amag;
   logic [WIDTH-1:0] bmag;
   logic [WIDTH:0]   msum;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign bus.busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

   always_comb begin
      op     = md_op_e'(bus.MDOp);
      sgn_op = (op == MD_MULT) || (op == MD_DIV);
      sa     = sgn_op & bus.A[WIDTH-1];
      sb     = sgn_op & bus.B[WIDTH-1];
      amag   = WIDTH'(neg_if(NEG_MAXW'(bus.A), sa));
      bmag   = WIDTH'(neg_if(NEG_MAXW'(bus.B), sb));
   end

   // Shift-add: the multiplier drains out of acc_lo as the
   // product's low half shifts in from the top.
   always_comb begin
      msum = {1'b0, acc_hi}
           + (acc_lo[0] ? {1'b0, opd} : '0);
   end

   md_divstep #(
      .WIDTH(WIDTH)
   ) u_divstep (
      .rem     (acc_hi),
      .quo     (acc_lo),
      .divisor (opd),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   always_comb begin
      prod_fix = (2*WIDTH)'(neg_if(NEG_MAXW'({acc_hi, acc_lo}), neg_q));
      q_fix    = WIDTH'(neg_if(NEG_MAXW'(acc_lo), neg_q));
      r_fix    = WIDTH'(neg_if(NEG_MAXW'(acc_hi), neg_r));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         opd    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  unique case (1'b1)
                     (op == MD_MULT) || (op == MD_MULTU): begin
                        opd    <= amag;
                        acc_hi <= '0;
                        acc_lo <= bmag;
                        neg_q  <= sa ^ sb;
                        neg_r  <= 1'b0;
                        is_div <= 1'b0;
                        dz     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_MUL;
                     end
                     (op == MD_DIV) || (op == MD_DIVU): begin
                        opd    <= bmag;
                        acc_hi <= '0;
                        acc_lo <= amag;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        is_div <= 1'b1;
                        dz     <= (bus.B == '0);
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_DIV;
                     end
                     (op == MD_MTHI): hi_q <= bus.A;
                     (op == MD_MTLO): lo_q <= bus.A;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               {acc_hi, acc_lo} <= {msum, acc_lo[WIDTH-1:1]};
               cnt <= cnt + CW'(1);
               if (cnt == LAST) state <= S_FIX;
            end
            S_DIV: begin
               acc_hi <= rem_nxt;
               acc_lo <= quo_nxt;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) state <= S_FIX;
            end
            S_FIX: begin
               // Zero divisor leaves |A| as remainder, so r_fix is A.
               if (is_div) begin
                  hi_q <= r_fix;
                  lo_q <= dz ? '1 : q_fix;
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
               cnt    <= '0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed and random checks of md_unit against a plain
// arithmetic model of mult/multu/div/divu/mthi/mtlo.
module tb_md_unit;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   md_unit_if #(.WIDTH(32)) mif ();

   md_unit #(
      .WIDTH(32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint x;
      longint y;
      int     q;
      int     r;
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = 0;
      r = 0;
      case (op)
         3'd1: return 64'(x * y);
         3'd2: return {32'b0, a} * {32'b0, b};
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         3'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return {hi_m, lo_m};
      endcase
   endfunction

   // inj_at: busy cycle at which a one-cycle mthi is attempted.
   // rst_at: busy cycle at which reset is pulsed between edges.
   task automatic run_op(input string tag,
                         input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int inj_at,
                         input int rst_at);
      int cycles;
      logic held;
      logic [63:0] exp;
      exp = model(op, a, b);
      @(negedge clk);
      mif.start = 1'b1;
      mif.MDOp  = op;
      mif.A     = a;
      mif.B     = b;
      @(negedge clk);
      mif.start = 1'b0;
      mif.A     = $urandom;
      mif.B     = $urandom;
      cycles = 0;
      held   = 1'b1;
      while (mif.busy === 1'b1 && cycles < 100) begin
         cycles++;
         if (mif.HI !== hi_m || mif.LO !== lo_m) held = 1'b0;
         mif.start = 1'b0;
         if (cycles == inj_at) begin
            mif.start = 1'b1;
            mif.MDOp  = 3'd5;
            mif.A     = 32'h0000_AAAA;
         end
         if (cycles == rst_at) begin
            #2 reset = 1'b1;
            #1;
            check({tag, "_rst_busy"}, 64'(mif.busy), 64'd0);
            check({tag, "_rst_hilo"}, {mif.HI, mif.LO}, 64'd0);
            hi_m = '0;
            lo_m = '0;
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         @(negedge clk);
      end
      mif.start = 1'b0;
      check({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
      check({tag, "_held"}, 64'(held), 64'd1);
      hi_m = exp[63:32];
      lo_m = exp[31:0];
      check({tag, "_hilo"}, {mif.HI, mif.LO}, exp);
   endtask

   task automatic move(input string tag,
                       input logic [2:0] op,
                       input logic [31:0] a);
      @(negedge clk);
      mif.start = 1'b1;
      mif.MDOp  = op;
      mif.A     = a;
      mif.B     = $urandom;
      @(negedge clk);
      mif.start = 1'b0;
      if (op == 3'd5) hi_m = a;
      if (op == 3'd6) lo_m = a;
      check({tag, "_busy"}, 64'(mif.busy), 64'd0);
      check({tag, "_hilo"}, {mif.HI, mif.LO}, {hi_m, lo_m});
   endtask

   initial begin
      errors = 0;
      checks = 0;
      hi_m   = '0;
      lo_m   = '0;
      reset  = 1'b1;
      mif.start = 1'b0;
      mif.MDOp  = 3'd0;
      mif.A     = '0;
      mif.B     = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(mif.busy), 64'd0);
      check("reset_hilo", {mif.HI, mif.LO}, 64'd0);
      reset = 1'b0;

      run_op("mult_neg3", 3'd1, 32'hFFFF_FFFD, 32'd1, -1, -1);
      check("mult_neg3_const", {mif.HI, mif.LO},
            64'hFFFF_FFFF_FFFF_FFFD);
      run_op("multu_max2", 3'd2, 32'hFFFF_FFFF, 32'd2, -1, -1);
      check("multu_max2_const", {mif.HI, mif.LO},
            64'h0000_0001_FFFF_FFFE);
      run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, -1, -1);
      check("div_m7_2_const", {mif.HI, mif.LO},
            64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_min_m1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      check("div_min_m1_const", {mif.HI, mif.LO},
            64'h0000_0000_8000_0000);
      run_op("divu_by0", 3'd4, 32'd7, 32'd0, -1, -1);
      check("divu_by0_const", {mif.HI, mif.LO},
            64'h0000_0007_FFFF_FFFF);
      run_op("div_neg_by0", 3'd3, 32'hFFFF_FF00, 32'd0, -1, -1);
      run_op("mult_minmin", 3'd1, 32'h8000_0000, 32'h8000_0000, -1, -1);
      check("mult_minmin_const", {mif.HI, mif.LO},
            64'h4000_0000_0000_0000);

      run_op("mult_inj", 3'd1, 32'd5, 32'd6, 10, -1);
      check("mult_inj_const", {mif.HI, mif.LO}, 64'd30);
      run_op("mult_rst", 3'd1, 32'd5, 32'd6, -1, 20);
      run_op("post_rst", 3'd4, 32'd100, 32'd7, -1, -1);

      move("mtlo", 3'd6, 32'h0000_1234);
      move("mthi", 3'd5, 32'h0000_0055);
      move("nop0", 3'd0, 32'hDEAD_BEEF);
      move("nop7", 3'd7, 32'hCAFE_F00D);

      for (int i = 0; i < 16; i++) begin
         logic [2:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = 3'($urandom_range(1, 4));
         a  = $urandom;
         b  = $urandom;
         if (i % 3 == 0) b = 32'($urandom_range(1, 9));
         if (i % 3 == 0 && a[0]) b = -b;
         if (i % 7 == 3) b = 32'd0;
         run_op("rand", op, a, b, -1, -1);
         if (i % 4 == 1) move("rand_mv", 3'($urandom_range(5, 6)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
